// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug reporter: FSM encoding, ASCII constants,
// nibble-to-ASCII conversion and a constant log2 for pointer/timer widths.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    TERM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debug_uart_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit; CLKS_PER_BIT clocks per bit.
// Latency: tx_pin drives the start bit on the edge that samples start.
// Backpressure: start is taken when idle or on the last stop-bit clock (done), giving back-to-back frames.
module debug_uart_tx
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx_pin,
  output logic       busy,
  output logic       done
);

  localparam int TW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [3:0]    bit_idx;
  logic [TW-1:0] timer;
  logic [8:0]    shreg;

  assign busy = active;
  assign done = active && (bit_idx == 4'd9) && (timer == T_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      active  <= 1'b0;
      tx_pin  <= 1'b1;
      bit_idx <= 4'd0;
      timer   <= '0;
      shreg   <= '1;
    end else if (start && (!active || done)) begin
      active  <= 1'b1;
      tx_pin  <= 1'b0;
      bit_idx <= 4'd0;
      timer   <= '0;
      shreg   <= {1'b1, data};
    end else if (active) begin
      if (timer == T_LAST) begin
        // timer reloads at every bit boundary so bit widths never drift
        timer <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx_pin <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx_pin  <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_reporter.sv
// Buffers debug samples in a FIFO and reports them over UART as raw bytes or ASCII hex + CR/LF (DEBUG_DROP_COUNT_EN adds a drop counter).
// Latency: a sample accepted at edge N on an idle block pops at N+1; its start bit begins at N+2.
// Backpressure: sample_ready is low while the FIFO is full; samples offered then are dropped.
module debug_reporter
  import debug_pkg::*;
#(
  parameter int CLOCK_HZ  = 12_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int HEX_MODE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             tx_pin,
  output logic             busy,
  output logic [7:0]       leds,
  output logic [15:0]      drop_count
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int AW      = clog2(DEPTH);
  localparam int BYTES   = (WIDTH + 7) / 8;
  localparam int NIBBLES = (WIDTH + 3) / 4;
  localparam int UNITS   = (HEX_MODE != 0) ? NIBBLES : BYTES;
  localparam int W_REG   = 8 * BYTES;
  localparam int ALIGN   = (HEX_MODE != 0) ? (W_REG - 4 * NIBBLES) : 0;
  localparam int SHIFT   = (HEX_MODE != 0) ? 4 : 8;

  // ---------------- FIFO ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             empty, wr_en, pop;

  assign empty        = (count == '0);
  assign sample_ready = (count != (AW+1)'(DEPTH));
  assign wr_en        = sample_valid && sample_ready;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- formatting FSM ----------------
  state_t           state, state_nxt;
  logic [W_REG-1:0] word, load_val;
  logic [6:0]       idx;
  logic             lf_sent;
  logic [7:0]       sent_cnt;
  logic [7:0]       cur_char, tx_byte;
  logic             tx_start, tx_done, tx_busy;
  logic             advance, start_lf, inc_sent;

  // head sample left-aligned so the next unit to send is always at the top of word
  assign load_val = W_REG'(mem[rd_ptr]) << ALIGN;
  assign cur_char = (HEX_MODE != 0) ? hex_ascii(word[W_REG-1 -: 4]) : word[W_REG-1 -: 8];

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = cur_char;
    advance   = 1'b0;
    start_lf  = 1'b0;
    inc_sent  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx_start  = 1'b1;
        advance   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (tx_done) begin
          if (idx < 7'(UNITS)) begin
            tx_start = 1'b1;
            advance  = 1'b1;
          end else if (HEX_MODE != 0) begin
            tx_start  = 1'b1;
            tx_byte   = ASCII_CR;
            state_nxt = TERM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      TERM: begin
        if (tx_done) begin
          if (!lf_sent) begin
            tx_start = 1'b1;
            tx_byte  = ASCII_LF;
            start_lf = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        inc_sent  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      word     <= '0;
      idx      <= '0;
      lf_sent  <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        word    <= load_val;
        idx     <= '0;
        lf_sent <= 1'b0;
      end
      if (advance) begin
        word <= word << SHIFT;
        idx  <= idx + 7'd1;
      end
      if (start_lf) lf_sent  <= 1'b1;
      if (inc_sent) sent_cnt <= sent_cnt + 8'd1;
    end
  end

  debug_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock  (clock),
    .reset  (reset),
    .start  (tx_start),
    .data   (tx_byte),
    .tx_pin (tx_pin),
    .busy   (tx_busy),
    .done   (tx_done)
  );

  assign busy = (state != IDLE) || !empty || tx_busy;
  assign leds = sent_cnt;

`ifdef DEBUG_DROP_COUNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (sample_valid && !sample_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_debug_reporter.sv
// Bench: three reporters (hex/32, raw/12, raw/8) at 12 clk/bit, a UART receiver per pin and a
// byte-stream reference model built from the formatting rules.
module tb_debug_reporter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        hex_rst, hex_valid, hex_ready, hex_tx, hex_busy;
  logic [31:0] hex_data;
  logic [7:0]  hex_leds;
  logic [15:0] hex_drop;
  logic        r12_rst, r12_valid, r12_ready, r12_tx, r12_busy;
  logic [11:0] r12_data;
  logic [7:0]  r12_leds;
  logic [15:0] r12_drop;
  logic        r8_rst, r8_valid, r8_ready, r8_tx, r8_busy;
  logic [7:0]  r8_data;
  logic [7:0]  r8_leds;
  logic [15:0] r8_drop;

  debug_reporter #(.CLOCK_HZ(12_000_000), .BAUD_RATE(1_000_000), .WIDTH(32), .DEPTH(16), .HEX_MODE(1)) u_hex (
    .clock(clock), .reset(hex_rst), .sample_data(hex_data), .sample_valid(hex_valid), .sample_ready(hex_ready),
    .tx_pin(hex_tx), .busy(hex_busy), .leds(hex_leds), .drop_count(hex_drop));
  debug_reporter #(.CLOCK_HZ(12_000_000), .BAUD_RATE(1_000_000), .WIDTH(12), .DEPTH(16), .HEX_MODE(0)) u_r12 (
    .clock(clock), .reset(r12_rst), .sample_data(r12_data), .sample_valid(r12_valid), .sample_ready(r12_ready),
    .tx_pin(r12_tx), .busy(r12_busy), .leds(r12_leds), .drop_count(r12_drop));
  debug_reporter #(.CLOCK_HZ(12_000_000), .BAUD_RATE(1_000_000), .WIDTH(8), .DEPTH(16), .HEX_MODE(0)) u_r8 (
    .clock(clock), .reset(r8_rst), .sample_data(r8_data), .sample_valid(r8_valid), .sample_ready(r8_ready),
    .tx_pin(r8_tx), .busy(r8_busy), .leds(r8_leds), .drop_count(r8_drop));

`ifdef DEBUG_DROP_COUNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_buf  [3][1024];
  logic [7:0] exp_buf [3][1024];
  int rx_n  [3] = '{0, 0, 0};
  int exp_n [3] = '{0, 0, 0};
  int ferr  [3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int id);
    return (id == 0) ? 32 : (id == 1) ? 12 : 8;
  endfunction

  function automatic logic get_tx(input int id);
    return (id == 0) ? hex_tx : (id == 1) ? r12_tx : r8_tx;
  endfunction
  function automatic logic get_busy(input int id);
    return (id == 0) ? hex_busy : (id == 1) ? r12_busy : r8_busy;
  endfunction
  function automatic logic get_ready(input int id);
    return (id == 0) ? hex_ready : (id == 1) ? r12_ready : r8_ready;
  endfunction
  function automatic logic [7:0] get_leds(input int id);
    return (id == 0) ? hex_leds : (id == 1) ? r12_leds : r8_leds;
  endfunction

  task automatic set_in(input int id, input logic v, input logic [63:0] d);
    case (id)
      0:       begin hex_valid = v; hex_data = d[31:0]; end
      1:       begin r12_valid = v; r12_data = d[11:0]; end
      default: begin r8_valid  = v; r8_data  = d[7:0];  end
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: the byte sequence a sample must produce on the wire.
  task automatic expect_sample(input int id, input logic [63:0] v);
    int n;
    logic [63:0] u;
    if (id == 0) begin
      n = (wid(id) + 3) / 4;
      for (int i = n - 1; i >= 0; i--) begin
        u = (v >> (4 * i)) & 64'hF;
        exp_buf[id][exp_n[id]++] = (u < 10) ? 8'(48 + u) : 8'(55 + u);
      end
      exp_buf[id][exp_n[id]++] = 8'd13;
      exp_buf[id][exp_n[id]++] = 8'd10;
    end else begin
      n = (wid(id) + 7) / 8;
      for (int i = n - 1; i >= 0; i--) begin
        exp_buf[id][exp_n[id]++] = 8'((v >> (8 * i)) & 64'hFF);
      end
    end
  endtask

  // UART receiver sampling near mid-bit on falling clock edges.
  task automatic monitor(input int id);
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (get_tx(id) === 1'b0) begin
        repeat (5) @(negedge clock);
        if (get_tx(id) !== 1'b0) ferr[id]++;
        for (int k = 0; k < 8; k++) begin
          repeat (12) @(negedge clock);
          b[k] = get_tx(id);
        end
        repeat (12) @(negedge clock);
        if (get_tx(id) !== 1'b1) ferr[id]++;
        if (rx_n[id] < 1024) begin
          rx_buf[id][rx_n[id]] = b;
          rx_n[id]++;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic push1(input int id, input logic [63:0] d);
    set_in(id, 1'b1, d);
    expect_sample(id, d);
    step();
    set_in(id, 1'b0, 64'd0);
  endtask

  task automatic wait_idle(input int id, input int budget, output int cyc);
    cyc = 0;
    while (get_busy(id) && cyc < budget) begin
      step();
      cyc++;
    end
    if (get_busy(id)) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic cmp_stream(input int id, input string tag);
    int n;
    check({tag, "_len"}, 64'(rx_n[id]), 64'(exp_n[id]));
    n = (rx_n[id] < exp_n[id]) ? rx_n[id] : exp_n[id];
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_b%0d", tag, i), 64'(rx_buf[id][i]), 64'(exp_buf[id][i]));
    end
    check({tag, "_framing"}, 64'(ferr[id]), 64'd0);
    rx_n[id] = 0;
    exp_n[id] = 0;
    ferr[id] = 0;
  endtask

  // Random producer; accepted samples go to the model, longest ready run is reported.
  task automatic stream(input int id, input int nsamp, input int gap_max, input int budget, output int max_run);
    int sent, cyc, run;
    logic v;
    logic [63:0] d;
    sent = 0; cyc = 0; run = 0; max_run = 0;
    while (sent < nsamp && cyc < budget) begin
      v = ($urandom_range(0, gap_max) == 0);
      d = {$urandom, $urandom} & ((64'd1 << wid(id)) - 64'd1);
      set_in(id, v, d);
      if (v && get_ready(id)) begin
        expect_sample(id, d);
        sent++;
      end
      run = (v && get_ready(id)) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      step();
      cyc++;
    end
    set_in(id, 1'b0, 64'd0);
    check("stream_accepted", 64'(sent), 64'(nsamp));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, mism, run;
    logic [9:0] frame;
    logic [63:0] d;
    for (int id = 0; id < 3; id++) set_in(id, 1'b0, 64'd0);
    hex_rst = 1'b1; r12_rst = 1'b1; r8_rst = 1'b1;
    repeat (3) step();
    check("rst_tx", 64'(hex_tx), 64'd1);
    check("rst_busy", 64'(hex_busy), 64'd0);
    check("rst_ready", 64'(hex_ready), 64'd1);
    check("rst_leds", 64'(hex_leds), 64'd0);
    check("rst_drop", 64'(r8_drop), 64'd0);
    hex_rst = 1'b0; r12_rst = 1'b0; r8_rst = 1'b0;
    step();

    // hex, 32-bit: DEADBEEF -> "DEADBEEF\r\n"
    push1(0, 64'hDEADBEEF);
    step();
    check("t1_tx_at_pop", 64'(hex_tx), 64'd1);
    step();
    check("t1_tx_fall", 64'(hex_tx), 64'd0);
    wait_idle(0, 3000, c);
    check("t1_cycles", 64'(c + 2), 64'd1203);
    check("t1_leds", 64'(hex_leds), 64'd1);
    cmp_stream(0, "t1");

    // raw, 12-bit: ABC -> 0A BC
    push1(1, 64'hABC);
    step();
    check("t2_tx_at_pop", 64'(r12_tx), 64'd1);
    step();
    check("t2_tx_fall", 64'(r12_tx), 64'd0);
    wait_idle(1, 1000, c);
    check("t2_cycles", 64'(c + 2), 64'd243);
    check("t2_leds", 64'(r12_leds), 64'd1);
    cmp_stream(1, "t2");

    // raw, 8-bit: exact waveform of a single 0x01 frame
    frame = {1'b1, 8'h01, 1'b0};
    mism = 0;
    push1(2, 64'h01);
    for (int k = 1; k <= 125; k++) begin
      step();
      if (k == 2) check("t3_fall", 64'(r8_tx), 64'd0);
      if (r8_tx !== ((k >= 2 && k < 122) ? frame[(k - 2) / 12] : 1'b1)) mism++;
    end
    check("t3_wave_mismatches", 64'(mism), 64'd0);
    check("t3_busy", 64'(r8_busy), 64'd0);
    cmp_stream(2, "t3");

    // overflow: 20 back-to-back offers, 17 fit
    for (int i = 0; i < 20; i++) begin
      d = 64'($urandom_range(0, 255));
      set_in(2, 1'b1, d);
      check($sformatf("t4_ready_%0d", i), 64'(r8_ready), (i < 17) ? 64'd1 : 64'd0);
      if (i < 17) expect_sample(2, d);
      step();
    end
    set_in(2, 1'b0, 64'd0);
    check("t4_drop", 64'(r8_drop), 64'(EXP_DROP));

    // full FIFO under continuous offers: each pop refills exactly one slot
    stream(2, 30, 0, 6000, run);
    check("t6_ready_run", 64'(run), 64'd1);
    wait_idle(2, 5000, c);
    check("t46_leds", 64'(r8_leds), 64'd48);
    cmp_stream(2, "t46");

    // reset in the middle of a hex sample
    push1(0, 64'($urandom));
    repeat (499) step();
    hex_rst = 1'b1;
    step();
    hex_rst = 1'b0;
    check("t5_tx", 64'(hex_tx), 64'd1);
    check("t5_busy", 64'(hex_busy), 64'd0);
    check("t5_leds", 64'(hex_leds), 64'd0);
    check("t5_ready", 64'(hex_ready), 64'd1);
    repeat (130) step();
    rx_n[0] = 0; exp_n[0] = 0; ferr[0] = 0;
    push1(0, 64'h0123ABCD);
    step();
    step();
    check("t5_tx_fall", 64'(hex_tx), 64'd0);
    wait_idle(0, 3000, c);
    check("t5_cycles", 64'(c + 2), 64'd1203);
    check("t5_leds_after", 64'(hex_leds), 64'd1);
    cmp_stream(0, "t5");

    // random traffic on both remaining formats
    stream(0, 6, 3, 12000, run);
    wait_idle(0, 10000, c);
    check("rand_hex_leds", 64'(hex_leds), 64'd7);
    cmp_stream(0, "rand_hex");
    stream(1, 8, 2, 4000, run);
    wait_idle(1, 4000, c);
    check("rand_r12_leds", 64'(get_leds(1)), 64'd9);
    cmp_stream(1, "rand_r12");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
